arbitro_vc_wrr: RTL and testbench
=================================

# arbitro_vc_wrr

Weighted round-robin arbiter that drains the two virtual-channel FIFOs (VC0, VC1) into the two destination FIFOs (D0, D1) of the QoS datapath. It runs only while the control state machine reports the datapath active. Each head word is routed by its destination bit. A VC whose head targets an almost-full destination is skipped. Pop requests are combinational; the forwarded word and its push strobe are registered.

## Interface
- DATA_WIDTH, 6: width of a FIFO word.
- DEST_BIT, 4: bit of the word that selects the destination (0 → D0, 1 → D1).
- PESO_VC0, 3: consecutive grants allowed to VC0 per round; legal range 1..15.
- PESO_VC1, 1: consecutive grants allowed to VC1 per round; legal range 1..15.

- clk  in  1  single clock; all state updates on its rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- enable  in  1  arbitration allowed; driven from the controller's active indication.
- vc0_empty, vc1_empty  in  1 each  VC FIFO empty flags.
- vc0_data, vc1_data  in  DATA_WIDTH each  show-ahead head word; valid whenever the matching empty flag is 0.
- d0_almost_full, d1_almost_full  in  1 each  destination FIFO almost-full flags.
- vc0_pop, vc1_pop  out  1 each  combinational pop; at most one is high per cycle.
- data_out  out  DATA_WIDTH  registered word forwarded to the destinations.
- push_d0, push_d1  out  1 each  registered push strobes; at most one is high per cycle.
- vc_sel  out  1  registered index of the VC that supplied data_out.

## Operation
- elig0 = reset_L & enable & !vc0_empty & !almost_full(vc0_data[DEST_BIT]). elig1 is defined the same way for VC1.
- State machine: IDLE, SERVE_VC0, SERVE_VC1, plus a 4-bit credit counter.
- IDLE:
  - elig0 → grant VC0, next state SERVE_VC0, credit=1.
  - else elig1 → grant VC1, next state SERVE_VC1, credit=1.
  - else no grant, stay in IDLE.
  - VC0 wins a tie.
- SERVE_VC0:
  - elig0 & credit<PESO_VC0 → grant VC0, credit+1.
  - else elig1 → grant VC1, next state SERVE_VC1, credit=1.
  - else elig0 (credit spent, VC1 not eligible) → grant VC0, credit=1, stay in SERVE_VC0.
  - else no grant, next state IDLE, credit=0.
- SERVE_VC1: mirror of SERVE_VC0, using PESO_VC1 and elig0.
- enable=0: no grant, next state IDLE, credit=0. Nothing is in flight to cancel because pop and push complete in consecutive cycles.
- vcN_pop equals the grant to VC N in the same cycle.
- Registered outputs on a grant:
  - data_out <= granted head word;
  - vc_sel <= granted VC;
  - push_d0 <= (word[DEST_BIT]==0);
  - push_d1 <= (word[DEST_BIT]==1).
- With no grant: push_d0=push_d1=0; data_out and vc_sel hold.
- Almost-full must leave at least 1 free slot, because a push lands one cycle after the decision.

## Timing
- Reset values while reset_L=0 (asynchronous):
  - state=IDLE, credit=0;
  - data_out=0, vc_sel=0, push_d0=0, push_d1=0;
  - vc0_pop=vc1_pop=0 immediately, even mid-operation.
- First grant possible in the first cycle after reset_L rises, when enable and eligibility hold.
- Latency: pop in cycle N; data_out and push in cycle N+1. Throughput is 1 word per cycle.
- almost_full asserting in cycle N blocks grants to that destination in cycle N. A push already registered in cycle N still occurs in N+1.
- VC empty asserting in cycle N blocks any pop of that VC in cycle N.
- The credit counter never exceeds the active weight.

## Test plan
- Reset mid-stream:
  - Stimulus: reset_L dropped while vc0_pop=1.
  - Required: pops go to 0 in the same cycle; all registered outputs 0 before the next edge. After release with both VCs empty: no pops.
- Weighted rotation:
  - Stimulus: PESO 3/1; both VCs full; all heads target D0; enable=1.
  - Required: pop sequence VC0,VC0,VC0,VC1 repeating. push_d0 follows 1 cycle later; vc_sel 0,0,0,1.
- Skip on back-pressure:
  - Stimulus: VC0 head targets D1 with d1_almost_full=1; VC1 head targets D0.
  - Required: only VC1 pops, and push_d0 is asserted. When d1_almost_full falls, VC0 is granted on the first eligible cycle.
- Credit reset when alone:
  - Stimulus: VC1 empty, VC0 holds 8 words.
  - Required: 8 consecutive VC0 pops, 8 push cycles, no gaps.
- Enable gating:
  - Stimulus: enable dropped mid-burst.
  - Required: no pops in that cycle. When enable returns, arbitration restarts from IDLE with a VC0 tie win.
- Routing:
  - Stimulus: alternate heads with DEST_BIT=0/1 on VC0.
  - Required: push_d0 and push_d1 alternate, and data_out matches each popped word 1 cycle later.

Source files
------------

// File: rtl/arbitro_vc_wrr_if.sv
// Handshake bundle between the VC/destination FIFOs and the weighted round-robin arbiter.
// The slave modport is the arbiter's view; master is the FIFO/controller side.
interface arbitro_vc_wrr_if #(
    parameter int DATA_WIDTH = 6
);
    logic                  enable;
    logic                  vc0_empty;
    logic                  vc1_empty;
    logic [DATA_WIDTH-1:0] vc0_data;
    logic [DATA_WIDTH-1:0] vc1_data;
    logic                  d0_almost_full;
    logic                  d1_almost_full;
    logic                  vc0_pop;
    logic                  vc1_pop;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  push_d0;
    logic                  push_d1;
    logic                  vc_sel;

    modport slave (
        input  enable, vc0_empty, vc1_empty, vc0_data, vc1_data,
               d0_almost_full, d1_almost_full,
        output vc0_pop, vc1_pop, data_out, push_d0, push_d1, vc_sel
    );

    modport master (
        output enable, vc0_empty, vc1_empty, vc0_data, vc1_data,
               d0_almost_full, d1_almost_full,
        input  vc0_pop, vc1_pop, data_out, push_d0, push_d1, vc_sel
    );
endinterface

// File: rtl/arbitro_vc_wrr.sv
// Weighted round-robin arbiter draining VC0/VC1 into destination FIFOs D0/D1.
// Pops are decided combinationally; the forwarded word and push strobes are registered.
module arbitro_vc_wrr #(
    parameter int DATA_WIDTH = 6,
    parameter int DEST_BIT   = 4,
    parameter int PESO_VC0   = 3,
    parameter int PESO_VC1   = 1
) (
    input  logic               clk,
    input  logic               reset_L,
    arbitro_vc_wrr_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SERVE_VC0,
        ST_SERVE_VC1
    } state_t;

    localparam logic [3:0] LP_PESO0 = 4'(PESO_VC0);
    localparam logic [3:0] LP_PESO1 = 4'(PESO_VC1);

    // A head is blocked when the destination it targets is almost full.
    function automatic logic f_dest_blocked(input logic dest, input logic af0, input logic af1);
        return dest ? af1 : af0;
    endfunction

    state_t                r_state_p1;
    logic [3:0]            r_credit_p1;
    logic [DATA_WIDTH-1:0] r_data_p1;
    logic                  r_vc_sel_p1;
    logic                  r_push_d0_p1;
    logic                  r_push_d1_p1;

    logic                  w_elig0_p0;
    logic                  w_elig1_p0;
    logic                  w_gnt0_p0;
    logic                  w_gnt1_p0;
    logic                  w_any_gnt_p0;
    state_t                w_state_nx_p0;
    logic [3:0]            w_credit_nx_p0;
    logic [DATA_WIDTH-1:0] w_word_p0;

    // ---- Stage p0: eligibility and grant decision (combinational, drives pops)
    assign w_elig0_p0 = reset_L & bus.enable & ~bus.vc0_empty &
                        ~f_dest_blocked(bus.vc0_data[DEST_BIT], bus.d0_almost_full, bus.d1_almost_full);
    assign w_elig1_p0 = reset_L & bus.enable & ~bus.vc1_empty &
                        ~f_dest_blocked(bus.vc1_data[DEST_BIT], bus.d0_almost_full, bus.d1_almost_full);

    always_comb begin
        w_gnt0_p0      = 1'b0;
        w_gnt1_p0      = 1'b0;
        w_state_nx_p0  = ST_IDLE;
        w_credit_nx_p0 = 4'd0;
        if (bus.enable) begin
            unique case (r_state_p1)
                ST_IDLE: begin
                    if (w_elig0_p0) begin
                        w_gnt0_p0      = 1'b1;
                        w_state_nx_p0  = ST_SERVE_VC0;
                        w_credit_nx_p0 = 4'd1;
                    end else if (w_elig1_p0) begin
                        w_gnt1_p0      = 1'b1;
                        w_state_nx_p0  = ST_SERVE_VC1;
                        w_credit_nx_p0 = 4'd1;
                    end
                end
                ST_SERVE_VC0: begin
                    if (w_elig0_p0 && (r_credit_p1 < LP_PESO0)) begin
                        w_gnt0_p0      = 1'b1;
                        w_state_nx_p0  = ST_SERVE_VC0;
                        w_credit_nx_p0 = r_credit_p1 + 4'd1;
                    end else if (w_elig1_p0) begin
                        w_gnt1_p0      = 1'b1;
                        w_state_nx_p0  = ST_SERVE_VC1;
                        w_credit_nx_p0 = 4'd1;
                    end else if (w_elig0_p0) begin
                        // Credit spent but the other VC has nothing to offer: start a fresh round.
                        w_gnt0_p0      = 1'b1;
                        w_state_nx_p0  = ST_SERVE_VC0;
                        w_credit_nx_p0 = 4'd1;
                    end
                end
                ST_SERVE_VC1: begin
                    if (w_elig1_p0 && (r_credit_p1 < LP_PESO1)) begin
                        w_gnt1_p0      = 1'b1;
                        w_state_nx_p0  = ST_SERVE_VC1;
                        w_credit_nx_p0 = r_credit_p1 + 4'd1;
                    end else if (w_elig0_p0) begin
                        w_gnt0_p0      = 1'b1;
                        w_state_nx_p0  = ST_SERVE_VC0;
                        w_credit_nx_p0 = 4'd1;
                    end else if (w_elig1_p0) begin
                        w_gnt1_p0      = 1'b1;
                        w_state_nx_p0  = ST_SERVE_VC1;
                        w_credit_nx_p0 = 4'd1;
                    end
                end
                default: begin
                    w_state_nx_p0  = ST_IDLE;
                    w_credit_nx_p0 = 4'd0;
                end
            endcase
        end
    end

    assign w_any_gnt_p0 = w_gnt0_p0 | w_gnt1_p0;
    assign w_word_p0    = w_gnt1_p0 ? bus.vc1_data : bus.vc0_data;

    // ---- Stage p1: registered forward word, push strobes and FSM state
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state_p1   <= ST_IDLE;
            r_credit_p1  <= 4'd0;
            r_data_p1    <= '0;
            r_vc_sel_p1  <= 1'b0;
            r_push_d0_p1 <= 1'b0;
            r_push_d1_p1 <= 1'b0;
        end else begin
            r_state_p1   <= w_state_nx_p0;
            r_credit_p1  <= w_credit_nx_p0;
            r_push_d0_p1 <= w_any_gnt_p0 & ~w_word_p0[DEST_BIT];
            r_push_d1_p1 <= w_any_gnt_p0 &  w_word_p0[DEST_BIT];
            if (w_any_gnt_p0) begin
                r_data_p1   <= w_word_p0;
                r_vc_sel_p1 <= w_gnt1_p0;
            end
        end
    end

    assign bus.vc0_pop  = w_gnt0_p0;
    assign bus.vc1_pop  = w_gnt1_p0;
    assign bus.data_out = r_data_p1;
    assign bus.vc_sel   = r_vc_sel_p1;
    assign bus.push_d0  = r_push_d0_p1;
    assign bus.push_d1  = r_push_d1_p1;

endmodule

// File: tb/tb_arbitro_vc_wrr.sv
// Bench for arbitro_vc_wrr: table of per-cycle vectors with expected pops, plus
// hand-written sequences; registered outputs are checked one cycle later from a scoreboard.
module tb_arbitro_vc_wrr;

    localparam bit H = 1'b1;
    localparam bit L = 1'b0;

    logic clk;
    logic reset_L;

    arbitro_vc_wrr_if #(.DATA_WIDTH(6)) bus();

    arbitro_vc_wrr #(
        .DATA_WIDTH(6),
        .DEST_BIT  (4),
        .PESO_VC0  (3),
        .PESO_VC1  (1)
    ) dut (
        .clk    (clk),
        .reset_L(reset_L),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       e0;
        logic       e1;
        logic [5:0] d0;
        logic [5:0] d1;
        logic       af0;
        logic       af1;
        logic       xp0;
        logic       xp1;
    } vec_t;

    typedef struct packed {
        logic       vld;
        logic [5:0] data;
        logic       sel;
    } exp_t;

    vec_t       tbl [19];
    exp_t       sb [$];
    int         tests = 0;
    int         fails = 0;
    logic [5:0] last_data;
    logic       last_sel;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_regs(input string nm);
        exp_t e;
        logic pd0, pd1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.vld) begin
                last_data = e.data;
                last_sel  = e.sel;
                pd0 = ~e.data[4];
                pd1 =  e.data[4];
            end else begin
                pd0 = 1'b0;
                pd1 = 1'b0;
            end
            chk({nm, " data_out"}, {2'b0, bus.data_out}, {2'b0, last_data});
            chk({nm, " vc_sel"},   {7'b0, bus.vc_sel},   {7'b0, last_sel});
            chk({nm, " push_d0"},  {7'b0, bus.push_d0},  {7'b0, pd0});
            chk({nm, " push_d1"},  {7'b0, bus.push_d1},  {7'b0, pd1});
        end
    endtask

    task automatic step(input logic en, input logic e0, input logic e1,
                        input logic [5:0] d0, input logic [5:0] d1,
                        input logic af0, input logic af1,
                        input logic xp0, input logic xp1, input string nm);
        exp_t e;
        @(negedge clk);
        check_regs(nm);
        bus.enable         = en;
        bus.vc0_empty      = e0;
        bus.vc1_empty      = e1;
        bus.vc0_data       = d0;
        bus.vc1_data       = d1;
        bus.d0_almost_full = af0;
        bus.d1_almost_full = af1;
        #1;
        chk({nm, " vc0_pop"}, {7'b0, bus.vc0_pop}, {7'b0, xp0});
        chk({nm, " vc1_pop"}, {7'b0, bus.vc1_pop}, {7'b0, xp1});
        e.vld  = xp0 | xp1;
        e.data = xp1 ? d1 : d0;
        e.sel  = xp1;
        sb.push_back(e);
    endtask

    task automatic reset_sb();
        exp_t e;
        sb.delete();
        last_data = 6'h00;
        last_sel  = 1'b0;
        e.vld  = 1'b0;
        e.data = 6'h00;
        e.sel  = 1'b0;
        sb.push_back(e);
    endtask

    initial begin
        // en e0 e1 d0 d1 af0 af1 xp0 xp1
        tbl[0]  = '{H, L, L, 6'h01, 6'h21, L, L, H, L};
        tbl[1]  = '{H, L, L, 6'h02, 6'h21, L, L, H, L};
        tbl[2]  = '{H, L, L, 6'h03, 6'h21, L, L, H, L};
        tbl[3]  = '{H, L, L, 6'h04, 6'h21, L, L, L, H};
        tbl[4]  = '{H, L, L, 6'h04, 6'h22, L, L, H, L};
        tbl[5]  = '{H, L, L, 6'h05, 6'h22, L, L, H, L};
        tbl[6]  = '{H, L, L, 6'h11, 6'h22, L, H, L, H};
        tbl[7]  = '{H, L, L, 6'h11, 6'h23, L, H, L, H};
        tbl[8]  = '{H, L, L, 6'h11, 6'h24, L, L, H, L};
        tbl[9]  = '{L, L, L, 6'h12, 6'h24, L, L, L, L};
        tbl[10] = '{H, L, L, 6'h12, 6'h24, L, L, H, L};
        tbl[11] = '{H, H, L, 6'h3F, 6'h24, L, L, L, H};
        tbl[12] = '{H, L, H, 6'h06, 6'h3F, L, L, H, L};
        tbl[13] = '{H, H, H, 6'h06, 6'h3F, L, L, L, L};
        tbl[14] = '{H, H, L, 6'h06, 6'h35, L, L, L, H};
        tbl[15] = '{H, H, L, 6'h06, 6'h07, L, L, L, H};
        tbl[16] = '{H, L, L, 6'h08, 6'h09, H, L, L, L};
        tbl[17] = '{H, L, L, 6'h13, 6'h09, H, L, H, L};
        tbl[18] = '{L, H, H, 6'h00, 6'h00, L, L, L, L};

        reset_L            = 1'b0;
        bus.enable         = 1'b0;
        bus.vc0_empty      = 1'b1;
        bus.vc1_empty      = 1'b1;
        bus.vc0_data       = 6'h00;
        bus.vc1_data       = 6'h00;
        bus.d0_almost_full = 1'b0;
        bus.d1_almost_full = 1'b0;
        #1;
        chk("reset data_out", {2'b0, bus.data_out}, 8'h00);
        chk("reset push_d0",  {7'b0, bus.push_d0},  8'h00);
        chk("reset push_d1",  {7'b0, bus.push_d1},  8'h00);
        chk("reset vc_sel",   {7'b0, bus.vc_sel},   8'h00);
        repeat (2) @(negedge clk);
        reset_L = 1'b1;
        reset_sb();

        for (int i = 0; i < 19; i++)
            step(tbl[i].en, tbl[i].e0, tbl[i].e1, tbl[i].d0, tbl[i].d1,
                 tbl[i].af0, tbl[i].af1, tbl[i].xp0, tbl[i].xp1, $sformatf("tbl[%0d]", i));

        // VC0 alone with 8 words of alternating destination: no gaps after credit runs out.
        for (int i = 0; i < 8; i++)
            step(H, L, H, (i % 2 == 1) ? (6'h10 | 6'(i)) : 6'(i), 6'h00, L, L, H, L,
                 $sformatf("alone[%0d]", i));
        step(H, H, H, 6'h00, 6'h00, L, L, L, L, "alone_end");

        // Reset dropped while VC0 is popping.
        step(H, L, H, 6'h2A, 6'h00, L, L, H, L, "pre_reset");
        #1 reset_L = 1'b0;
        #1;
        chk("midrst vc0_pop",  {7'b0, bus.vc0_pop},  8'h00);
        chk("midrst vc1_pop",  {7'b0, bus.vc1_pop},  8'h00);
        chk("midrst data_out", {2'b0, bus.data_out}, 8'h00);
        chk("midrst push_d0",  {7'b0, bus.push_d0},  8'h00);
        chk("midrst push_d1",  {7'b0, bus.push_d1},  8'h00);
        chk("midrst vc_sel",   {7'b0, bus.vc_sel},   8'h00);
        bus.vc0_empty = 1'b1;
        @(negedge clk);
        reset_L = 1'b1;
        reset_sb();
        step(H, H, H, 6'h2A, 6'h15, L, L, L, L, "postrst[0]");
        step(H, H, H, 6'h2A, 6'h15, L, L, L, L, "postrst[1]");

        // Weighted rotation from IDLE with both VCs backlogged toward D0.
        begin
            int i0 = 0;
            int i1 = 0;
            logic x1;
            for (int k = 0; k < 12; k++) begin
                x1 = (k % 4 == 3);
                step(H, L, L, 6'(i0), 6'h20 | 6'(i1), L, L, ~x1, x1, $sformatf("rot[%0d]", k));
                if (x1) i1++;
                else    i0++;
            end
        end
        step(L, H, H, 6'h00, 6'h00, L, L, L, L, "final");
        @(negedge clk);
        check_regs("final_regs");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
